// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Optional build macro IFETCH_BYPASS_EN enables the response-to-FIFO bypass path.
package ifetch_pkg;

  localparam int unsigned ADDR_WIDTH        = 32;
  localparam int unsigned INSTR_WIDTH       = 32;
  localparam int unsigned FETCH_ENTRY_WIDTH = ADDR_WIDTH + INSTR_WIDTH;
  localparam int unsigned PC_INC            = 4;
  localparam logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_1000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifetch_fsm.sv
// Fetch control: request/response/hold sequencing and stale-response drop tracking.
// With IFETCH_BYPASS_EN a clean response may enqueue in its arrival cycle.
module ifetch_fsm
  import ifetch_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_ready,
  input  logic resp_valid,
  input  logic redirect_valid,
  input  logic enq_ready,
`ifdef IFETCH_BYPASS_EN
  output logic enq_bypass_c,
`endif
  output logic req_valid_c,
  output logic capture_c,
  output logic pc_inc_c,
  output logic enq_valid_c
);

  fetch_state_e state_q, state_d;
  logic         drop_q, drop_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // Next state; drop marks an in-flight response that belongs to a redirected-away PC
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    case (state_q)
      FETCH: begin
        if (req_ready) begin
          state_d = WAIT;
          drop_d  = redirect_valid;
        end
      end
      WAIT: begin
        if (resp_valid) begin
          drop_d = 1'b0;
          if (drop_q || redirect_valid) begin
            state_d = FETCH;
`ifdef IFETCH_BYPASS_EN
          end else if (enq_ready) begin
            state_d = FETCH;
`endif
          end else begin
            state_d = HOLD;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid || enq_ready) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
        drop_d  = 1'b0;
      end
    endcase
  end

  // Control enables
  always_comb begin
    req_valid_c = 1'b0;
    capture_c   = 1'b0;
    pc_inc_c    = 1'b0;
    enq_valid_c = 1'b0;
`ifdef IFETCH_BYPASS_EN
    enq_bypass_c = 1'b0;
`endif
    case (state_q)
      FETCH: req_valid_c = 1'b1;
      WAIT: begin
        if (resp_valid && !drop_q && !redirect_valid) begin
`ifdef IFETCH_BYPASS_EN
          if (enq_ready) begin
            enq_valid_c  = 1'b1;
            enq_bypass_c = 1'b1;
            pc_inc_c     = 1'b1;
          end else begin
            capture_c = 1'b1;
          end
`else
          capture_c = 1'b1;
`endif
        end
      end
      HOLD: begin
        enq_valid_c = !redirect_valid;
        pc_inc_c    = !redirect_valid && enq_ready;
      end
      default: ;
    endcase
  end

  // A response is only legal while a request is outstanding
  resp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
    resp_valid |-> (state_q == WAIT));

endmodule

// File: rtl/ifetch_stage.sv
// Fetch stage: PC and hold-register datapath around ifetch_fsm, feeding the instruction FIFO.
// Define IFETCH_BYPASS_EN to enqueue clean responses combinationally in their arrival cycle.
module ifetch_stage #(
  parameter int unsigned ADDR_WIDTH  = ifetch_pkg::ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = ifetch_pkg::INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(ifetch_pkg::RESET_PC)
) (
  input  logic                              clk,
  input  logic                              rst_aH,
  output logic                              icache_req_valid,
  input  logic                              icache_req_ready,
  output logic [ADDR_WIDTH-1:0]             icache_req_addr,
  input  logic                              icache_resp_valid,
  input  logic [INSTR_WIDTH-1:0]            icache_resp_data,
  input  logic                              redirect_valid,
  input  logic [ADDR_WIDTH-1:0]             redirect_pc,
  input  logic                              fifo_enq_ready,
  output logic                              fifo_enq_valid,
  output logic [ADDR_WIDTH+INSTR_WIDTH-1:0] fifo_enq_data
);

  localparam int unsigned ENTRY_W = ADDR_WIDTH + INSTR_WIDTH;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ENTRY_W-1:0]    hold_q, hold_d;
  logic                  capture_c, pc_inc_c;
`ifdef IFETCH_BYPASS_EN
  logic                  enq_bypass_c;
`endif

  ifetch_fsm u_fsm (
    .clk            (clk),
    .rst            (rst_aH),
    .req_ready      (icache_req_ready),
    .resp_valid     (icache_resp_valid),
    .redirect_valid (redirect_valid),
    .enq_ready      (fifo_enq_ready),
`ifdef IFETCH_BYPASS_EN
    .enq_bypass_c   (enq_bypass_c),
`endif
    .req_valid_c    (icache_req_valid),
    .capture_c      (capture_c),
    .pc_inc_c       (pc_inc_c),
    .enq_valid_c    (fifo_enq_valid)
  );

  // Redirect always wins over sequential advance; the increment wraps silently
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~ADDR_WIDTH'(3);
    end else if (pc_inc_c) begin
      pc_d = pc_q + ADDR_WIDTH'(ifetch_pkg::PC_INC);
    end
  end

  always_comb begin
    hold_d = hold_q;
    if (capture_c) begin
      hold_d = {pc_q, icache_resp_data};
    end
  end

  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      pc_q   <= RESET_PC;
      hold_q <= '0;
    end else begin
      pc_q   <= pc_d;
      hold_q <= hold_d;
    end
  end

  assign icache_req_addr = pc_q;

`ifdef IFETCH_BYPASS_EN
  assign fifo_enq_data = enq_bypass_c ? {pc_q, icache_resp_data} : hold_q;
`else
  assign fifo_enq_data = hold_q;
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed self-checking bench for ifetch_stage; expectations adapt when IFETCH_BYPASS_EN is defined.
module tb_ifetch_stage;

  logic        clk = 1'b0;
  logic        rst_aH;
  logic        icache_req_valid;
  logic        icache_req_ready;
  logic [31:0] icache_req_addr;
  logic        icache_resp_valid;
  logic [31:0] icache_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fifo_enq_ready;
  logic        fifo_enq_valid;
  logic [63:0] fifo_enq_data;

  int checks = 0;
  int errors = 0;

  ifetch_stage dut (
    .clk               (clk),
    .rst_aH            (rst_aH),
    .icache_req_valid  (icache_req_valid),
    .icache_req_ready  (icache_req_ready),
    .icache_req_addr   (icache_req_addr),
    .icache_resp_valid (icache_resp_valid),
    .icache_resp_data  (icache_resp_data),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .fifo_enq_ready    (fifo_enq_ready),
    .fifo_enq_valid    (fifo_enq_valid),
    .fifo_enq_data     (fifo_enq_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled in the low phase
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete fetch starting in FETCH with the FIFO ready
  task automatic fetch_one(input logic [31:0] pc, input logic [31:0] ins);
    check("req_valid", 64'(icache_req_valid), 64'd1);
    check("req_addr", 64'(icache_req_addr), 64'(pc));
    check("idle_enq_valid", 64'(fifo_enq_valid), 64'd0);
    icache_req_ready = 1'b1;
    step();
    icache_req_ready = 1'b0;
    check("wait_req_valid", 64'(icache_req_valid), 64'd0);
    icache_resp_valid = 1'b1;
    icache_resp_data  = ins;
    #1;
`ifdef IFETCH_BYPASS_EN
    check("bypass_enq_valid", 64'(fifo_enq_valid), 64'd1);
    check("bypass_enq_data", fifo_enq_data, {pc, ins});
    step();
    icache_resp_valid = 1'b0;
`else
    check("wait_enq_valid", 64'(fifo_enq_valid), 64'd0);
    step();
    icache_resp_valid = 1'b0;
    #1;
    check("hold_enq_valid", 64'(fifo_enq_valid), 64'd1);
    check("hold_enq_data", fifo_enq_data, {pc, ins});
    step();
`endif
  endtask

  initial begin
    rst_aH            = 1'b1;
    icache_req_ready  = 1'b0;
    icache_resp_valid = 1'b0;
    icache_resp_data  = '0;
    redirect_valid    = 1'b0;
    redirect_pc       = '0;
    fifo_enq_ready    = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_valid", 64'(icache_req_valid), 64'd1);
    check("rst_req_addr", 64'(icache_req_addr), 64'h1000);
    check("rst_enq_valid", 64'(fifo_enq_valid), 64'd0);
    check("rst_enq_data", fifo_enq_data, 64'd0);
    rst_aH = 1'b0;

    // Sequential stream with everything ready
    fetch_one(32'h1000, 32'hA000_0000);
    fetch_one(32'h1004, 32'hA000_0001);
    fetch_one(32'h1008, 32'hA000_0002);

    // FIFO back-pressure while holding an entry
    fifo_enq_ready   = 1'b0;
    check("bp_req_addr", 64'(icache_req_addr), 64'h100C);
    icache_req_ready = 1'b1;
    step();
    icache_req_ready  = 1'b0;
    icache_resp_valid = 1'b1;
    icache_resp_data  = 32'hA000_0003;
    #1;
    check("bp_resp_enq_valid", 64'(fifo_enq_valid), 64'd0);
    step();
    icache_resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_enq_valid", 64'(fifo_enq_valid), 64'd1);
      check("bp_enq_data", fifo_enq_data, {32'h100C, 32'hA000_0003});
      check("bp_no_req", 64'(icache_req_valid), 64'd0);
      step();
    end
    fifo_enq_ready = 1'b1;
    #1;
    check("bp_release_valid", 64'(fifo_enq_valid), 64'd1);
    step();

    // Redirect while waiting: next response is stale
    check("wr_req_addr", 64'(icache_req_addr), 64'h1010);
    icache_req_ready = 1'b1;
    step();
    icache_req_ready = 1'b0;
    redirect_valid   = 1'b1;
    redirect_pc      = 32'h2002;
    step();
    redirect_valid = 1'b0;
    check("wr_still_wait", 64'(icache_req_valid), 64'd0);
    icache_resp_valid = 1'b1;
    icache_resp_data  = 32'hDEAD_0001;
    #1;
    check("wr_stale_no_enq", 64'(fifo_enq_valid), 64'd0);
    step();
    icache_resp_valid = 1'b0;
    #1;
    check("wr_after_enq_valid", 64'(fifo_enq_valid), 64'd0);
    fetch_one(32'h2000, 32'hA000_0004);

    // Redirect while holding with the FIFO ready
    fifo_enq_ready   = 1'b0;
    icache_req_ready = 1'b1;
    step();
    icache_req_ready  = 1'b0;
    icache_resp_valid = 1'b1;
    icache_resp_data  = 32'hDEAD_0002;
    step();
    icache_resp_valid = 1'b0;
    #1;
    check("hr_holding", 64'(fifo_enq_valid), 64'd1);
    fifo_enq_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3007;
    #1;
    check("hr_enq_suppressed", 64'(fifo_enq_valid), 64'd0);
    step();
    redirect_valid = 1'b0;
    fetch_one(32'h3004, 32'hA000_0005);

    // Redirect coinciding with request acceptance
    icache_req_ready = 1'b1;
    redirect_valid   = 1'b1;
    redirect_pc      = 32'h4000;
    step();
    icache_req_ready = 1'b0;
    redirect_valid   = 1'b0;
    check("fr_wait", 64'(icache_req_valid), 64'd0);
    icache_resp_valid = 1'b1;
    icache_resp_data  = 32'hDEAD_0003;
    #1;
    check("fr_stale_no_enq", 64'(fifo_enq_valid), 64'd0);
    step();
    icache_resp_valid = 1'b0;
    fetch_one(32'h4000, 32'hA000_0006);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    fetch_one(32'hFFFF_FFFC, 32'hA000_0007);
    check("wrap_req_addr", 64'(icache_req_addr), 64'h0);
    fetch_one(32'h0000_0000, 32'hA000_0008);
    check("wrap_next_addr", 64'(icache_req_addr), 64'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
